frame_receiver: RTL

FRAME_RECEIVER -- requirements
Module: frame_receiver

---
 rtl/frame_receiver.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/frame_receiver.sv
// Serial frame receiver: synchronises MCU sclk/data/latch, shifts in frames and commits them to segment/anode outputs.
// Optional checksum byte appended to each frame when FRAME_CHECKSUM_EN is defined.
module frame_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        data,
    input  logic        latch,
    output logic [27:0] red_seg,
    output logic [27:0] grn_seg,
    output logic [23:0] led_an,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [1:0]  err_cause,
    output logic        busy
);

`ifdef FRAME_CHECKSUM_EN
    localparam int FW = 104;
`else
    localparam int FW = 96;
`endif
    localparam logic [6:0] FRAME_LEN = 7'(FW);
    localparam int TW = $clog2(TIMEOUT + 1);

`ifdef FRAME_CHECKSUM_EN
    function automatic logic [7:0] byte_xor(input logic [95:0] p);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < 12; i++) begin
            acc = acc ^ p[8*i +: 8];
        end
        return acc;
    endfunction
`endif

    logic [SYNC_STAGES-1:0] sclk_sync, data_sync, latch_sync;
    logic          sclk_d, latch_d, data_d;
    logic          sclk_rise, latch_rise;
    logic [FW-1:0] shreg;
    logic [6:0]    bit_cnt;
    logic [TW-1:0] idle_cnt;
    logic [95:0]   payload;
    logic          cks_ok;
    logic [27:0]   next_red, next_grn;
    logic [23:0]   next_an;
    logic [15:0]   pad_unused;

    // Pin synchronisers plus the registered edge detectors; data is delayed to stay aligned with the sclk edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync  <= '0;
            data_sync  <= '0;
            latch_sync <= '0;
            sclk_d     <= 1'b0;
            latch_d    <= 1'b0;
            data_d     <= 1'b0;
            sclk_rise  <= 1'b0;
            latch_rise <= 1'b0;
        end else begin
            sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            data_sync  <= {data_sync[SYNC_STAGES-2:0], data};
            latch_sync <= {latch_sync[SYNC_STAGES-2:0], latch};
            sclk_d     <= sclk_sync[SYNC_STAGES-1];
            latch_d    <= latch_sync[SYNC_STAGES-1];
            data_d     <= data_sync[SYNC_STAGES-1];
            sclk_rise  <= sclk_sync[SYNC_STAGES-1] & ~sclk_d;
            latch_rise <= latch_sync[SYNC_STAGES-1] & ~latch_d;
        end
    end

    // Unpack the payload into per-digit colour and anode fields; padding bits are dropped
    always_comb begin
        next_red   = 28'h0;
        next_grn   = 28'h0;
        next_an    = 24'h0;
        pad_unused = 16'h0;
`ifdef FRAME_CHECKSUM_EN
        payload = shreg[103:8];
        cks_ok  = (byte_xor(payload) == shreg[7:0]);
`else
        payload = shreg[95:0];
        cks_ok  = 1'b1;
`endif
        for (int n = 0; n < 4; n++) begin
            next_red[7*n +: 7]   = payload[24*n + 16 +: 7];
            next_grn[7*n +: 7]   = payload[24*n + 8 +: 7];
            next_an[6*n +: 6]    = payload[24*n +: 6];
            pad_unused[4*n +: 4] = {payload[24*n + 23], payload[24*n + 15], payload[24*n + 7], payload[24*n + 6]};
        end
    end

    // Frame state: latch evaluation wins over a coincident sclk bit, then shifting, then the idle timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg       <= '0;
            bit_cnt     <= 7'd0;
            idle_cnt    <= '0;
            red_seg     <= 28'h0;
            grn_seg     <= 28'h0;
            led_an      <= 24'h0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_cause   <= 2'b00;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (latch_rise) begin
                bit_cnt  <= 7'd0;
                idle_cnt <= '0;
                if (bit_cnt != FRAME_LEN) begin
                    frame_err <= 1'b1;
                    err_cause <= 2'b01;
                end else if (!cks_ok) begin
                    frame_err <= 1'b1;
                    err_cause <= 2'b10;
                end else begin
                    red_seg     <= next_red;
                    grn_seg     <= next_grn;
                    led_an      <= next_an;
                    frame_valid <= 1'b1;
                    err_cause   <= 2'b00;
                end
            end else if (sclk_rise) begin
                shreg    <= {shreg[FW-2:0], data_d};
                bit_cnt  <= (bit_cnt == 7'd127) ? bit_cnt : bit_cnt + 7'd1;
                idle_cnt <= '0;
            end else if (busy) begin
                if (idle_cnt == TW'(TIMEOUT - 1)) begin
                    bit_cnt  <= 7'd0;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + TW'(1);
                end
            end else begin
                idle_cnt <= '0;
            end
        end
    end

    assign busy = (bit_cnt != 7'd0);

endmodule
